// File: rtl/mac_requant_pkg.sv
// mac_requant_pkg: shared widths and saturation bounds for the requantization stage.
package mac_requant_pkg;

  localparam int ACC_BIT_DEF    = 20;
  localparam int BIAS_BIT_DEF   = 20;
  localparam int ACT_BIT_DEF    = 8;
  localparam int SHIFT_BIT_DEF  = 5;
  localparam int NUM_CH_MAX_DEF = 16;

  // Largest value representable by a signed activation of the given width.
  function automatic int act_max(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  // Smallest value representable by a signed activation of the given width.
  function automatic int act_min(input int bits);
    return -(1 << (bits - 1));
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// requant_round_sat: combinational core of the requantizer.
// The rounding half (sum -> r) feeds the stage 2 register; the clamp half
// (r -> act) feeds the stage 3 register. The two halves work on different
// samples in the same cycle, so they share no signals.
module requant_round_sat
  import mac_requant_pkg::*;
#(
  parameter int ACC_BIT   = ACC_BIT_DEF,
  parameter int ACT_BIT   = ACT_BIT_DEF,
  parameter int SHIFT_BIT = SHIFT_BIT_DEF
) (
  input  logic signed [ACC_BIT:0]   sum,
  input  logic        [SHIFT_BIT-1:0] shift,
  output logic signed [ACC_BIT+1:0] rnd_out,
  input  logic signed [ACC_BIT+1:0] sat_in,
  input  logic                      relu,
  output logic signed [ACT_BIT-1:0] act
);

  localparam int R_W = ACC_BIT + 2;
  localparam logic        [SHIFT_BIT-1:0] SHIFT_MAX = SHIFT_BIT'(ACC_BIT);
  localparam logic signed [R_W-1:0]       R_MAX     = R_W'(act_max(ACT_BIT));
  localparam logic signed [R_W-1:0]       R_MIN     = R_W'(act_min(ACT_BIT));

  logic        [SHIFT_BIT-1:0] sh_eff;
  logic signed [R_W-1:0]       sum_ext;
  logic signed [R_W-1:0]       half;
  logic signed [R_W-1:0]       biased;

  // Round-half-up arithmetic right shift; a zero shift adds nothing and passes sum through.
  always_comb begin
    sh_eff  = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    sum_ext = R_W'(sum);
    half    = '0;
    if (sh_eff != '0) begin
      half = R_W'(1) <<< (sh_eff - SHIFT_BIT'(1));
    end
    biased  = sum_ext + half;
    rnd_out = biased >>> sh_eff;
  end

  // Clamp to the activation range; relu pins negatives to zero first.
  always_comb begin
    act = sat_in[ACT_BIT-1:0];
    if (relu && sat_in[R_W-1]) begin
      act = '0;
    end else if (sat_in > R_MAX) begin
      act = ACT_BIT'(act_max(ACT_BIT));
    end else if (sat_in < R_MIN) begin
      act = ACT_BIT'(act_min(ACT_BIT));
    end
  end

endmodule

// File: rtl/mac_requant.sv
// mac_requant: bias add, rounding right shift and saturation of MAC
// accumulator results, as a 3-stage valid/ready pipeline with a plain
// stall chain (no skid buffer).
// Optional build macro MAC_REQUANT_RELU_EN adds the cfg_relu input.
module mac_requant
  import mac_requant_pkg::*;
#(
  parameter int ACC_BIT    = ACC_BIT_DEF,
  parameter int BIAS_BIT   = BIAS_BIT_DEF,
  parameter int ACT_BIT    = ACT_BIT_DEF,
  parameter int SHIFT_BIT  = SHIFT_BIT_DEF,
  parameter int NUM_CH_MAX = NUM_CH_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  input  logic [ACC_BIT-1:0]            acc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACT_BIT-1:0]            out_data,
  output logic                          out_last,
  input  logic [SHIFT_BIT-1:0]          cfg_shift,
  input  logic [$clog2(NUM_CH_MAX):0]   cfg_num_ch,
  input  logic                          bias_wr_en,
  input  logic [$clog2(NUM_CH_MAX)-1:0] bias_wr_addr,
  input  logic [BIAS_BIT-1:0]           bias_wr_data
`ifdef MAC_REQUANT_RELU_EN
  ,
  input  logic                          cfg_relu
`endif
);

  localparam int CNT_W = $clog2(NUM_CH_MAX);
  localparam int SUM_W = ACC_BIT + 1;
  localparam int R_W   = ACC_BIT + 2;
  localparam logic [CNT_W:0] NCH_MAX = (CNT_W + 1)'(NUM_CH_MAX);
  localparam logic [CNT_W:0] NCH_ONE = (CNT_W + 1)'(1);

  logic signed [BIAS_BIT-1:0] bias_mem [NUM_CH_MAX];

  logic [CNT_W-1:0] ch_cnt;
  logic [CNT_W:0]   num_eff;
  logic             ch_last;
  logic             ch_wrap;

  logic                    s1_valid;
  logic                    s1_last;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [SUM_W-1:0] sum_nxt;

  logic                    s2_valid;
  logic                    s2_last;
  logic signed [R_W-1:0]   s2_r;
  logic signed [R_W-1:0]   r_nxt;

  logic signed [ACT_BIT-1:0] act_nxt;

  logic s3_ready;
  logic s2_ready;
  logic s1_ready;
  logic in_fire;
  logic relu;

`ifdef MAC_REQUANT_RELU_EN
  assign relu = cfg_relu;
`else
  assign relu = 1'b0;
`endif

  assign s3_ready  = ~out_valid | out_ready;
  assign s2_ready  = ~s2_valid | s3_ready;
  assign s1_ready  = ~s1_valid | s2_ready;
  assign acc_ready = s1_ready;
  assign in_fire   = acc_valid & s1_ready;

  // Effective channel count (0 acts as 1, oversize clamps), end-of-row flags and the bias add.
  always_comb begin
    if (cfg_num_ch == '0) begin
      num_eff = NCH_ONE;
    end else if (cfg_num_ch > NCH_MAX) begin
      num_eff = NCH_MAX;
    end else begin
      num_eff = cfg_num_ch;
    end
    ch_last = ({1'b0, ch_cnt} == (num_eff - NCH_ONE));
    ch_wrap = ({1'b0, ch_cnt} >= (num_eff - NCH_ONE));
    sum_nxt = SUM_W'($signed(acc_data)) + SUM_W'(bias_mem[ch_cnt]);
  end

  // Bias register file; a same-cycle read sees the value from before the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH_MAX; i++) begin
        bias_mem[i] <= '0;
      end
    end else if (bias_wr_en) begin
      bias_mem[bias_wr_addr] <= $signed(bias_wr_data);
    end
  end

  // Channel counter advances on every accepted sample and wraps at the row end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt <= '0;
    end else if (in_fire) begin
      ch_cnt <= ch_wrap ? '0 : ch_cnt + CNT_W'(1);
    end
  end

  // Stage 1: biased sum and row-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (s1_ready) begin
      s1_valid <= acc_valid;
      if (acc_valid) begin
        s1_sum  <= sum_nxt;
        s1_last <= ch_last;
      end
    end
  end

  requant_round_sat #(
    .ACC_BIT  (ACC_BIT),
    .ACT_BIT  (ACT_BIT),
    .SHIFT_BIT(SHIFT_BIT)
  ) u_round_sat (
    .sum    (s1_sum),
    .shift  (cfg_shift),
    .rnd_out(r_nxt),
    .sat_in (s2_r),
    .relu   (relu),
    .act    (act_nxt)
  );

  // Stage 2: rounded, shifted value using the shift present while the sample sits in stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_r     <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_r    <= r_nxt;
        s2_last <= s1_last;
      end
    end
  end

  // Stage 3: saturated activation; holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s3_ready) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= act_nxt;
        out_last <= s2_last;
      end
    end
  end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Downstream stage of the MAC array.
- Consumes signed 20-bit accumulator results one per cycle and adds a per-output-channel bias.
- Rescales by a programmable right shift with round-half-up, clamps to the signed 8-bit activation format and hands the result to the next layer's input buffer.
- 3-stage pipeline with valid/ready handshaking on both sides and full backpressure support.

Parameters:
- ACC_BIT, 20, width of signed accumulator input (matches MAC output width)
- BIAS_BIT, 20, width of signed bias values
- ACT_BIT, 8, width of signed output activation
- SHIFT_BIT, 5, width of the requantization shift amount
- NUM_CH_MAX, 16, depth of the bias register file (max output channels)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- acc_valid  in  1  accumulator sample valid
- acc_ready  out  1  block can accept a sample this cycle
- acc_data  in  ACC_BIT  signed accumulator value
- out_valid  out  1  activation valid
- out_ready  in  1  downstream accepts activation
- out_data  out  ACT_BIT  signed requantized activation
- out_last  out  1  activation belongs to channel cfg_num_ch-1
- cfg_shift  in  SHIFT_BIT  right-shift amount, 0..ACC_BIT
- cfg_num_ch  in  clog2(NUM_CH_MAX)+1  active channel count
- bias_wr_en  in  1  bias register write strobe
- bias_wr_addr  in  clog2(NUM_CH_MAX)  bias register index
- bias_wr_data  in  BIAS_BIT  signed bias value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: out_valid=0, out_data=0, out_last=0, all internal stage valids=0, channel counter=0, all bias registers=0. acc_ready=1 from the first cycle after reset deassertion.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - acc_ready is asserted when stage 1 is empty or stage 1 advances this cycle (pipeline stall chain, no skid buffer).
- Latency and throughput: 3 cycles from input transfer to out_valid with out_ready held 1. Throughput is 1 sample per cycle.
- Stage 1:
  - sum = sext(acc_data) + sext(bias[ch_cnt]), computed at ACC_BIT+1 bits.
  - Registers last = (ch_cnt == cfg_num_ch-1).
  - On each input transfer, ch_cnt increments and wraps to 0 after cfg_num_ch-1.
  - cfg_num_ch=0 is treated as 1.
  - cfg_num_ch > NUM_CH_MAX is clamped to NUM_CH_MAX.
- Stage 2:
  - If cfg_shift>0: r = (sum + (1 << (cfg_shift-1))) >>> cfg_shift, arithmetic shift. Rounding is half toward +inf.
  - If cfg_shift=0: r = sum.
  - cfg_shift > ACC_BIT is treated as ACC_BIT.
  - Intermediate width is ACC_BIT+2 so no overflow.
- Stage 3: saturate r to [-2^(ACT_BIT-1), 2^(ACT_BIT-1)-1].
- Bias write/read collision: a bias write to the same index read in that cycle's stage 1 returns the old value. The write is visible from the next cycle.
- Config timing: cfg_shift is sampled by whichever sample occupies stage 2. cfg_num_ch and the bias registers are changed only while the pipeline is idle. Mid-stream changes are legal and follow the sampling rule above, but give mixed results.
- Reset mid-operation: in-flight samples are discarded and no out_valid pulse is produced. The channel counter restarts at 0.

Optional Feature:
- Macro: MAC_REQUANT_RELU_EN.
- Defined: adds input port cfg_relu (1 bit). When cfg_relu=1, stage 3 clamps negative results to 0 before saturation, so the range is [0, 2^(ACT_BIT-1)-1]. When cfg_relu=0, behaviour is as without the macro.
- Undefined: no cfg_relu port; pure signed saturation.

Decomposition:
- Shared package: ACC_BIT, ACT_BIT and BIAS_BIT defaults, and a saturation bounds constant per ACT_BIT.
- One natural sub-module: requant_round_sat (stage 2 rounding shift plus stage 3 clamp, combinational core). Pipeline registers and the handshake stay in the top.

Test Plan:
- Basic path: bias[0]=24, cfg_num_ch=1, cfg_shift=4, acc=1000 -> out_data=64, out_valid 3 cycles after the transfer, out_last=1.
- Rounding: shift=4, bias=0, acc=24 -> 2. acc=-24 -> -1. acc=8 -> 1. acc=-8 -> 0.
- Saturation:
  - acc=100000, shift=0 -> 127.
  - acc=-5000, shift=4 -> -128.
  - With MAC_REQUANT_RELU_EN and cfg_relu=1: acc=-5000 -> 0.
- Channel wrap: cfg_num_ch=3, bias=10,20,30, shift=0, four samples of acc=0 -> outputs 10,20,30,10; out_last high only on the third.
- Backpressure: stream 6 back-to-back samples with out_ready=0 for 5 cycles -> acc_ready drops after 3 accepted; after release all 6 outputs arrive in order with no loss or duplication.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid stays 0. The next sample after reset uses bias[0].
